// File: rtl/byte_logic_arbiter.sv
// Two-port round-robin arbiter feeding a single bitwise logic unit.
// Each accepted request runs IDLE -> EXEC -> DONE, one operation per three cycles.
module byte_logic_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;
  logic             win;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a ^ b;
      2'b10:   r = a;
      default: r = a | b;
    endcase
    return r;
  endfunction

  // last_q names the port granted most recently; on a tie the other port wins.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    res_d       = res_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    ops_done_d  = ops_done_q;
    win         = (req0 && req1) ? ~last_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          id_d    = win;
          last_d  = win;
          op_d    = win ? op1 : op0;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end
      end
      EXEC: begin
        state_d     = DONE;
        res_d       = logic_op(op_q, a_q, b_q);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        ops_done_d  = ops_done_q + CNTW'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_byte_logic_arbiter.sv
// Cycle-by-cycle vector bench for byte_logic_arbiter plus a counter-wrap sequence.
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
module tb_byte_logic_arbiter;

  logic       clk = 1'b0;
  logic       rst, req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, res_valid, res_id, busy;
  logic [7:0] res, ops_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       req0;
    logic [1:0] op0;
    logic [7:0] a0, b0;
    logic       req1;
    logic [1:0] op1;
    logic [7:0] a1, b1;
    logic       e_gnt0, e_gnt1, e_rv;
    logic [7:0] e_res;
    logic       e_id, e_busy;
    logic [7:0] e_od;
  } vec_t;

  vec_t vq[$];

  byte_logic_arbiter #(.WIDTH(8), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .res(res), .res_valid(res_valid),
    .res_id(res_id), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic q0, input logic [1:0] o0,
                              input logic [7:0] x0, input logic [7:0] y0,
                              input logic q1, input logic [1:0] o1,
                              input logic [7:0] x1, input logic [7:0] y1,
                              input logic g0, input logic g1, input logic rv,
                              input logic [7:0] rs, input logic id, input logic bz,
                              input logic [7:0] od);
    vec_t v;
    v.rst = r; v.req0 = q0; v.op0 = o0; v.a0 = x0; v.b0 = y0;
    v.req1 = q1; v.op1 = o1; v.a1 = x1; v.b1 = y1;
    v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_rv = rv; v.e_res = rs;
    v.e_id = id; v.e_busy = bz; v.e_od = od;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; req0 = v.req0; op0 = v.op0; a0 = v.a0; b0 = v.b0;
    req1 = v.req1; op1 = v.op1; a1 = v.a1; b1 = v.b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    check({t, ".gnt0"}, {7'd0, gnt0}, {7'd0, v.e_gnt0});
    check({t, ".gnt1"}, {7'd0, gnt1}, {7'd0, v.e_gnt1});
    check({t, ".res_valid"}, {7'd0, res_valid}, {7'd0, v.e_rv});
    check({t, ".res"}, res, v.e_res);
    check({t, ".res_id"}, {7'd0, res_id}, {7'd0, v.e_id});
    check({t, ".busy"}, {7'd0, busy}, {7'd0, v.e_busy});
    check({t, ".ops_done"}, ops_done, v.e_od);
    check({t, ".gnt_overlap"}, {7'd0, gnt0 & gnt1}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;

    //           rst q0 op0 a0     b0     q1 op1 a1     b1     g0 g1 rv res    id bz od
    vq.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0));
    vq.push_back(mk(0, 1, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'd0));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h0A, 0, 1, 8'd1));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 8'd1));
    vq.push_back(mk(0, 1, 1, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h0A, 0, 1, 8'd1));
    vq.push_back(mk(0, 0, 1, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h05, 0, 1, 8'd2));
    vq.push_back(mk(0, 0, 1, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h05, 0, 0, 8'd2));
    // held request, operands disturbed while in flight
    vq.push_back(mk(0, 1, 2, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 0, 1, 8'd2));
    vq.push_back(mk(0, 1, 3, 8'h33, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h0F, 0, 1, 8'd3));
    vq.push_back(mk(0, 1, 3, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h0F, 0, 0, 8'd3));
    vq.push_back(mk(0, 1, 3, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h0F, 0, 1, 8'd3));
    vq.push_back(mk(0, 0, 3, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h0F, 0, 1, 8'd4));
    vq.push_back(mk(0, 0, 3, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h0F, 0, 0, 8'd4));
    // reset dominates requests, then both ports contend
    vq.push_back(mk(1, 1, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 8'd0));
    vq.push_back(mk(0, 1, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 1, 0, 0, 8'h00, 0, 1, 8'd0));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 0, 1, 8'h0A, 0, 1, 8'd1));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h0A, 0, 0, 8'd1));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 1, 0, 8'h0A, 0, 1, 8'd1));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 1, 8'hF0, 8'hFF, 0, 0, 1, 8'h0F, 1, 1, 8'd2));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h0F, 1, 0, 8'd2));
    vq.push_back(mk(0, 1, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 1, 0, 0, 8'h0F, 1, 1, 8'd2));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 0, 1, 8'h0A, 0, 1, 8'd3));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h0A, 0, 0, 8'd3));
    vq.push_back(mk(0, 1, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 1, 0, 8'h0A, 0, 1, 8'd3));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 1, 8'hF0, 8'hFF, 0, 0, 1, 8'h0F, 1, 1, 8'd4));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h0F, 1, 0, 8'd4));
    // reset in EXEC aborts the operation
    vq.push_back(mk(0, 1, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h0F, 1, 1, 8'd4));
    vq.push_back(mk(1, 0, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0));
    // req1 pulsed only during EXEC is dropped
    vq.push_back(mk(0, 1, 0, 8'h0F, 8'h0A, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 1, 8'd0));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 1, 1, 8'hF0, 8'hFF, 0, 0, 1, 8'h0A, 0, 1, 8'd1));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h0A, 0, 0, 8'd1));
    vq.push_back(mk(0, 0, 0, 8'h0F, 8'h0A, 0, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h0A, 0, 0, 8'd1));

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i]);
      checkOutput(i, vq[i]);
    end

    // 255 more operations take ops_done from 1 round through 255 to 0
    for (int k = 0; k < 255; k++) begin
      @(negedge clk); req0 = 1'b1; op0 = 2'b01; a0 = k[7:0]; b0 = 8'hA5;
      @(posedge clk); #1;
      check($sformatf("wrap%0d.gnt0", k), {7'd0, gnt0}, 8'd1);
      @(negedge clk); req0 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("wrap%0d.res_valid", k), {7'd0, res_valid}, 8'd1);
      check($sformatf("wrap%0d.res", k), res, k[7:0] ^ 8'hA5);
      check($sformatf("wrap%0d.ops_done", k), ops_done, 8'((k + 2) % 256));
      @(posedge clk); #1;
      check($sformatf("wrap%0d.idle", k), {7'd0, busy}, 8'd0);
    end
    check("wrap.final_zero", ops_done, 8'd0);
    check("wrap.final_res", res, 8'hFE ^ 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_logic_arbiter.md
BYTE_LOGIC_ARBITER -- requirements
Module: byte_logic_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Parameter: CNTW, 8, width of completed-operation counter.
REQ-003 Ports use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 req0  input  1  requester 0 operation request; held high until gnt0.
REQ-006 op0  input  2  requester 0 opcode: 00 AND, 01 XOR, 10 BUF (result=a), 11 OR.
REQ-007 a0, b0  input  WIDTH each  requester 0 operands.
REQ-008 req1, op1, a1, b1  input  1/2/WIDTH/WIDTH  requester 1 equivalents.
REQ-009 gnt0, gnt1  output  1 each  one-cycle registered grant pulse; operands captured.
REQ-010 res  output  WIDTH  registered result of last completed operation.
REQ-011 res_valid  output  1  one-cycle pulse; res and res_id valid.
REQ-012 res_id  output  1  requester that owns res (0 or 1).
REQ-013 busy  output  1  high whenever FSM is not IDLE.
REQ-014 ops_done  output  CNTW  count of completed operations, wraps.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, DONE; transitions IDLE->EXEC on any req, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-016 In IDLE with no req, FSM SHALL remain in IDLE with all pulse outputs low.
REQ-017 At the edge where IDLE samples a request, the block SHALL latch winner's op, a, b, record winner id, and enter EXEC with that grant high for exactly that EXEC cycle.
REQ-018 Arbitration SHALL be round-robin: single request wins; simultaneous requests grant the port not granted last; after reset port 0 has priority.
REQ-019 Last-grant pointer SHALL update only on a grant.
REQ-020 At the EXEC->DONE edge the block SHALL register res = f(op, a, b) bitwise on all WIDTH bits, set res_id to winner, assert res_valid for the DONE cycle only, and increment ops_done.
REQ-021 Latency: request sampled at edge N -> gnt high cycle N..N+1 -> res_valid high cycle N+1..N+2; throughput one operation per 3 cycles.
REQ-022 Requests presented during EXEC or DONE SHALL be ignored and not queued; a held request SHALL be arbitrated on return to IDLE.
REQ-023 res and res_id SHALL hold their value until the next completion.
REQ-024 Operand or opcode changes after grant SHALL not affect the in-flight result.
REQ-025 ops_done SHALL wrap from 2^CNTW-1 to 0 without flag.
REQ-026 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-027 rst high at a rising edge SHALL force IDLE, gnt0=gnt1=0, res=0, res_valid=0, res_id=0, busy=0, ops_done=0, pointer to port-0 priority.
REQ-028 rst during EXEC or DONE SHALL abort the operation: no res_valid pulse, ops_done not incremented.
REQ-029 rst SHALL dominate any simultaneous request.

Verification
REQ-030 req0=1, op0=00, a0=0x0F, b0=0x0A -> gnt0 one cycle, next cycle res_valid=1, res=0x0A, res_id=0, ops_done=1.
REQ-031 Same operands with op 01, 10, 11 -> res 0x05, 0x0F, 0x0F respectively, each 3 cycles apart.
REQ-032 After reset, req0 and req1 both held (a1=0xF0, b1=0xFF, op1=01) -> port 0 served first, then gnt1, res=0x0F, res_id=1; gnt never overlaps.
REQ-033 rst asserted in EXEC cycle -> no res_valid, res=0, ops_done unchanged at 0, busy=0 next cycle.
REQ-034 req1 pulsed only during EXEC of port 0 -> never granted; 256 completed ops -> ops_done returns to 0.
